// File: rtl/v_instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : v_instr_issue_queue
// Purpose  : Vector-core side of the scalar-to-vector instruction interface.
//            Buffers {instr, rs1, rs2} in a DEPTH-entry FIFO, back-pressures
//            the scalar core with a registered stall, and dispatches the head
//            to the vector control unit over a valid/ready handshake. It also
//            tracks outstanding vector loads and stores so that the scalar
//            core can enforce memory ordering.
// Ports    : clk, rstn (async, active-low)
//            vector_instr_i/rs1_i/rs2_i/v_instr_valid_i  <- scalar core
//            vector_stall_o                               -> scalar core
//            instr_o/rs1_o/rs2_o/instr_valid_o, instr_ready_i <-> vector CU
//            load_done_i/store_done_i                     <- completion pulses
//            all_v_loads_executed_o/all_v_stores_executed_o -> scalar core
// Options  : V_ISSUE_BYPASS_EN - when defined, an instruction arriving at an
//            empty queue with the consumer ready is forwarded combinationally
//            and never written into the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module v_instr_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] vector_instr_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        v_instr_valid_i,
    output logic        vector_stall_o,
    output logic [31:0] instr_o,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        load_done_i,
    input  logic        store_done_i,
    output logic        all_v_loads_executed_o,
    output logic        all_v_stores_executed_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_Q_W = PTR_W + 1;
    localparam logic [CNT_Q_W-1:0] FULL_CNT = CNT_Q_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;

    logic [31:0]        mem_instr [DEPTH];
    logic [31:0]        mem_rs1   [DEPTH];
    logic [31:0]        mem_rs2   [DEPTH];

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_Q_W-1:0] count, count_nxt;
    logic [CNT_W-1:0]   ld_cnt, ld_cnt_nxt, st_cnt, st_cnt_nxt;
    logic               stall_q, ld_exec_q, st_exec_q;

    logic               push, bypass, wr_en, pop, empty;
    logic               is_load, is_store;

    assign empty    = (count == '0);
    // Stall is registered, so a pop in the same cycle never opens a slot for
    // a push until the next cycle.
    assign push     = v_instr_valid_i & ~stall_q;
    assign is_load  = push & (vector_instr_i[6:0] == OPC_LOAD);
    assign is_store = push & (vector_instr_i[6:0] == OPC_STORE);

`ifdef V_ISSUE_BYPASS_EN
    assign bypass = push & empty & instr_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign wr_en = push & ~bypass;
    assign pop   = ~empty & instr_ready_i;

    always_comb begin
        count_nxt = count;
        if (wr_en && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !wr_en) begin
            count_nxt = count - 1'b1;
        end
    end

    // Outstanding counters: inc and dec together cancel; dec at 0 saturates.
    // Increment cannot overflow because a counter at max raises stall.
    always_comb begin
        ld_cnt_nxt = ld_cnt;
        if (is_load && !load_done_i) begin
            ld_cnt_nxt = ld_cnt + 1'b1;
        end else if (load_done_i && !is_load && ld_cnt != '0) begin
            ld_cnt_nxt = ld_cnt - 1'b1;
        end
    end

    always_comb begin
        st_cnt_nxt = st_cnt;
        if (is_store && !store_done_i) begin
            st_cnt_nxt = st_cnt + 1'b1;
        end else if (store_done_i && !is_store && st_cnt != '0) begin
            st_cnt_nxt = st_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ld_cnt    <= '0;
            st_cnt    <= '0;
            stall_q   <= 1'b0;
            ld_exec_q <= 1'b1;
            st_exec_q <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count     <= count_nxt;
            ld_cnt    <= ld_cnt_nxt;
            st_cnt    <= st_cnt_nxt;
            stall_q   <= (count_nxt == FULL_CNT) | (ld_cnt_nxt == CNT_MAX)
                       | (st_cnt_nxt == CNT_MAX);
            ld_exec_q <= (ld_cnt_nxt == '0);
            st_exec_q <= (st_cnt_nxt == '0);
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_instr[wr_ptr] <= vector_instr_i;
            mem_rs1[wr_ptr]   <= rs1_i;
            mem_rs2[wr_ptr]   <= rs2_i;
        end
    end

    always_comb begin
        instr_o       = '0;
        rs1_o         = '0;
        rs2_o         = '0;
        instr_valid_o = 1'b0;
        if (!empty) begin
            instr_o       = mem_instr[rd_ptr];
            rs1_o         = mem_rs1[rd_ptr];
            rs2_o         = mem_rs2[rd_ptr];
            instr_valid_o = 1'b1;
        end else if (bypass) begin
            instr_o       = vector_instr_i;
            rs1_o         = rs1_i;
            rs2_o         = rs2_i;
            instr_valid_o = 1'b1;
        end
    end

    assign vector_stall_o          = stall_q;
    assign all_v_loads_executed_o  = ld_exec_q;
    assign all_v_stores_executed_o = st_exec_q;

endmodule
`default_nettype wire

// File: tb/tb_v_instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_instr_issue_queue
// Purpose  : Directed self-checking bench for v_instr_issue_queue (DEPTH=4,
//            CNT_W=6, bypass disabled). Inputs change and outputs are sampled
//            on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v_instr_issue_queue;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] vector_instr_i, rs1_i, rs2_i;
    logic        v_instr_valid_i, instr_ready_i, load_done_i, store_done_i;
    logic        vector_stall_o, instr_valid_o;
    logic [31:0] instr_o, rs1_o, rs2_o;
    logic        all_v_loads_executed_o, all_v_stores_executed_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    v_instr_issue_queue #(.DEPTH(4), .CNT_W(6)) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .vector_instr_i          (vector_instr_i),
        .rs1_i                   (rs1_i),
        .rs2_i                   (rs2_i),
        .v_instr_valid_i         (v_instr_valid_i),
        .vector_stall_o          (vector_stall_o),
        .instr_o                 (instr_o),
        .rs1_o                   (rs1_o),
        .rs2_o                   (rs2_o),
        .instr_valid_o           (instr_valid_o),
        .instr_ready_i           (instr_ready_i),
        .load_done_i             (load_done_i),
        .store_done_i            (store_done_i),
        .all_v_loads_executed_o  (all_v_loads_executed_o),
        .all_v_stores_executed_o (all_v_stores_executed_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Present an instruction for one cycle (ends on the next falling edge).
    task automatic push_one(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        vector_instr_i  = ins;
        rs1_i           = r1;
        rs2_i           = r2;
        v_instr_valid_i = 1'b1;
        @(negedge clk);
        v_instr_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int pushes;
        rstn = 1'b0;
        vector_instr_i = '0; rs1_i = '0; rs2_i = '0;
        v_instr_valid_i = 0; instr_ready_i = 0; load_done_i = 0; store_done_i = 0;
        idle(3);
        rstn = 1'b1;
        idle(2);

        // Reset / idle state
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_stall", {31'd0, vector_stall_o}, 32'd0);
        check("rst_ldflag", {31'd0, all_v_loads_executed_o}, 32'd1);
        check("rst_stflag", {31'd0, all_v_stores_executed_o}, 32'd1);
        check("rst_instr", instr_o, 32'd0);

        // Single load, one-cycle latency, flag cleared until load_done
        push_one(32'h02056007, 32'h0000_1000, 32'h0000_0022);
        check("ld_instr", instr_o, 32'h02056007);
        check("ld_rs1", rs1_o, 32'h0000_1000);
        check("ld_rs2", rs2_o, 32'h0000_0022);
        check("ld_valid", {31'd0, instr_valid_o}, 32'd1);
        check("ld_flag0", {31'd0, all_v_loads_executed_o}, 32'd0);
        instr_ready_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;
        check("ld_popped", {31'd0, instr_valid_o}, 32'd0);
        check("ld_flag_inflight", {31'd0, all_v_loads_executed_o}, 32'd0);
        load_done_i = 1'b1;
        @(negedge clk);
        load_done_i = 1'b0;
        check("ld_flag1", {31'd0, all_v_loads_executed_o}, 32'd1);

        // Fill to DEPTH, hold a 5th while stalled, then drain in order
        for (int k = 1; k <= 4; k++) begin
            check("fill_nostall", {31'd0, vector_stall_o}, 32'd0);
            push_one(32'h0000_0057 | (32'(k) << 12), 32'(k), 32'(k) + 32'd100);
        end
        check("full_stall", {31'd0, vector_stall_o}, 32'd1);
        vector_instr_i = 32'h0000_5057; rs1_i = 32'd5; rs2_i = 32'd105;
        v_instr_valid_i = 1'b1;
        idle(2);
        check("held_stall", {31'd0, vector_stall_o}, 32'd1);
        check("head_1", instr_o, 32'h0000_1057);
        instr_ready_i = 1'b1;
        @(negedge clk);
        check("stall_drop", {31'd0, vector_stall_o}, 32'd0);
        check("head_2", instr_o, 32'h0000_2057);
        @(negedge clk);                    // pop 2, accept 5th
        v_instr_valid_i = 1'b0;
        check("head_3", instr_o, 32'h0000_3057);
        @(negedge clk);
        check("head_4", instr_o, 32'h0000_4057);
        check("head_4_rs2", rs2_o, 32'd104);
        @(negedge clk);
        check("head_5", instr_o, 32'h0000_5057);
        check("head_5_rs1", rs1_o, 32'd5);
        @(negedge clk);
        instr_ready_i = 1'b0;
        check("drained", {31'd0, instr_valid_o}, 32'd0);

        // Half full, push a store while popping
        push_one(32'h0000_A057, 32'hA, 32'h0);
        push_one(32'h0000_B057, 32'hB, 32'h0);
        instr_ready_i = 1'b1;
        push_one(32'h0000_C027, 32'hC, 32'h0);
        instr_ready_i = 1'b0;
        check("st_flag0", {31'd0, all_v_stores_executed_o}, 32'd0);
        check("st_head_B", instr_o, 32'h0000_B057);
        check("st_nostall", {31'd0, vector_stall_o}, 32'd0);
        instr_ready_i = 1'b1;
        @(negedge clk);
        check("st_head_C", instr_o, 32'h0000_C027);
        @(negedge clk);
        instr_ready_i = 1'b0;
        check("st_empty", {31'd0, instr_valid_o}, 32'd0);
        store_done_i = 1'b1;
        @(negedge clk);
        check("st_flag1", {31'd0, all_v_stores_executed_o}, 32'd1);
        @(negedge clk);                    // second done with counter at 0
        store_done_i = 1'b0;
        check("st_sat0", {31'd0, all_v_stores_executed_o}, 32'd1);
        push_one(32'h0000_D027, 32'hD, 32'h0);
        check("st_after_sat", {31'd0, all_v_stores_executed_o}, 32'd0);
        store_done_i = 1'b1;
        @(negedge clk);
        store_done_i = 1'b0;
        check("st_back1", {31'd0, all_v_stores_executed_o}, 32'd1);
        instr_ready_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;

        // Load counter at 1 with simultaneous load push and load_done
        push_one(32'h0000_1007, 32'h1, 32'h0);
        load_done_i = 1'b1;
        push_one(32'h0000_2007, 32'h2, 32'h0);
        load_done_i = 1'b0;
        check("ld_cancel", {31'd0, all_v_loads_executed_o}, 32'd0);
        load_done_i = 1'b1;
        @(negedge clk);
        load_done_i = 1'b0;
        check("ld_cancel_1", {31'd0, all_v_loads_executed_o}, 32'd1);

        // Third entry, then asynchronous reset mid-cycle
        push_one(32'h0000_3007, 32'h3, 32'h0);
        check("pre_rst_valid", {31'd0, instr_valid_o}, 32'd1);
        check("pre_rst_ldflag", {31'd0, all_v_loads_executed_o}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("arst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("arst_instr", instr_o, 32'd0);
        check("arst_rs1", rs1_o, 32'd0);
        check("arst_ldflag", {31'd0, all_v_loads_executed_o}, 32'd1);
        check("arst_stall", {31'd0, vector_stall_o}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        instr_ready_i = 1'b1;
        idle(3);
        check("post_rst_nodispatch", {31'd0, instr_valid_o}, 32'd0);

        // Load counter saturating at 2^CNT_W-1 raises stall
        pushes = 0;
        vector_instr_i = 32'h0000_0007;
        v_instr_valid_i = 1'b1;
        for (int i = 0; i < 80 && !vector_stall_o; i++) begin
            pushes++;
            @(negedge clk);
        end
        check("cnt_max_pushes", 32'(pushes), 32'd63);
        check("cnt_max_stall", {31'd0, vector_stall_o}, 32'd1);
        idle(2);
        check("cnt_max_hold", {31'd0, vector_stall_o}, 32'd1);
        load_done_i = 1'b1;
        @(negedge clk);
        load_done_i = 1'b0;
        v_instr_valid_i = 1'b0;
        check("cnt_max_release", {31'd0, vector_stall_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
